mem_stage: RTL and testbench

- Memory-access stage of the 16-bit pipelined core; sits directly upstream of the write-back stage.
- Takes the EX/MEM bundle: address = ALU result, store data, and control signals.
- Runs a multi-cycle handshake with the data memory, stalls the upstream pipeline while the access is outstanding, and owns the MEM/WB pipeline register feeding write-back.
- Write-back selects memory data when MemtoReg=0 and the ALU result when MemtoReg=1; this block passes MemtoReg through unchanged.

---
 rtl/mem_stage.sv | 217 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage of the 16-bit pipelined core.
// Issues a one-cycle read/write request to data memory, waits for mem_done
// (bounded by MAX_WAIT cycles), stalls upstream while the access is
// outstanding, and owns the MEM/WB pipeline register.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   in_*                     EX/MEM bundle (valid, read, write, addr, wdata, controls)
//   mem_addr/mem_wdata       latched request address/data, stable ISSUE..WAIT
//   mem_rd/mem_wr            one-cycle request pulses
//   mem_done/mem_rdata       memory completion and read data
//   stall                    hold EX/MEM and all earlier stages
//   wb_*                     MEM/WB register toward write-back
//   err                      sticky error (misaligned, read+write, timeout)
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [15:0] in_addr,
    input  logic [15:0] in_wdata,
    input  logic        in_reg_write,
    input  logic [2:0]  in_write_reg,
    input  logic        in_MemtoReg,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [15:0] wb_alu_result,
    output logic [15:0] wb_read_data,
    output logic        wb_MemtoReg,
    output logic        wb_reg_write,
    output logic [2:0]  wb_write_reg,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_read_q, op_read_d;
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic [15:0]      mem_wdata_q, mem_wdata_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic             wb_valid_q, wb_valid_d;
    logic [15:0]      wb_alu_result_q, wb_alu_result_d;
    logic [15:0]      wb_read_data_q, wb_read_data_d;
    logic             wb_memtoreg_q, wb_memtoreg_d;
    logic             wb_reg_write_q, wb_reg_write_d;
    logic [2:0]       wb_write_reg_q, wb_write_reg_d;
    logic             err_q, err_d;

    logic memop, bad, timeout;

    assign memop   = in_valid & (in_mem_read ^ in_mem_write);
    assign bad     = in_valid & ((in_mem_read & in_mem_write) |
                                 ((in_mem_read | in_mem_write) & in_addr[0]));
    assign timeout = (cnt_q == CNT_W'(MAX_WAIT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (memop && !bad) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (mem_done || timeout) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic: stall drops in the completing WAIT cycle so upstream
    // advances on the same edge the result is captured.
    always_comb begin
        stall = 1'b0;
        unique case (state_q)
            StIdle:  stall = memop & ~bad;
            StIssue: stall = 1'b1;
            StWait:  stall = ~mem_done;
            default: stall = 1'b0;
        endcase
    end

    // Datapath next-state: request latches, wait counter, MEM/WB register
    always_comb begin
        cnt_d           = cnt_q;
        op_read_d       = op_read_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_rd_d        = 1'b0;
        mem_wr_d        = 1'b0;
        wb_valid_d      = wb_valid_q;
        wb_alu_result_d = wb_alu_result_q;
        wb_read_data_d  = wb_read_data_q;
        wb_memtoreg_d   = wb_memtoreg_q;
        wb_reg_write_d  = wb_reg_write_q;
        wb_write_reg_d  = wb_write_reg_q;
        err_d           = err_q;
        unique case (state_q)
            StIdle: begin
                if (bad) begin
                    // Squash: slot stays live but never writes the register file
                    err_d           = 1'b1;
                    wb_valid_d      = 1'b1;
                    wb_reg_write_d  = 1'b0;
                    wb_alu_result_d = in_addr;
                    wb_read_data_d  = 16'h0000;
                    wb_memtoreg_d   = in_MemtoReg;
                    wb_write_reg_d  = in_write_reg;
                end else if (memop) begin
                    mem_addr_d  = in_addr;
                    mem_wdata_d = in_wdata;
                    mem_rd_d    = in_mem_read;
                    mem_wr_d    = in_mem_write;
                    op_read_d   = in_mem_read;
                    wb_valid_d  = 1'b0;
                end else if (in_valid) begin
                    wb_valid_d      = 1'b1;
                    wb_alu_result_d = in_addr;
                    wb_read_data_d  = 16'h0000;
                    wb_memtoreg_d   = in_MemtoReg;
                    wb_reg_write_d  = in_reg_write;
                    wb_write_reg_d  = in_write_reg;
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            StIssue: begin
                cnt_d = '0;
            end
            StWait: begin
                if (mem_done) begin
                    // Upstream is held, so in_* still describe this access
                    wb_valid_d      = 1'b1;
                    wb_alu_result_d = in_addr;
                    wb_read_data_d  = op_read_q ? mem_rdata : 16'h0000;
                    wb_memtoreg_d   = in_MemtoReg;
                    wb_reg_write_d  = in_reg_write;
                    wb_write_reg_d  = in_write_reg;
                end else if (timeout) begin
                    err_d           = 1'b1;
                    wb_valid_d      = 1'b1;
                    wb_reg_write_d  = 1'b0;
                    wb_alu_result_d = in_addr;
                    wb_read_data_d  = 16'h0000;
                    wb_memtoreg_d   = in_MemtoReg;
                    wb_write_reg_d  = in_write_reg;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q           <= '0;
            op_read_q       <= 1'b0;
            mem_addr_q      <= 16'h0000;
            mem_wdata_q     <= 16'h0000;
            mem_rd_q        <= 1'b0;
            mem_wr_q        <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_alu_result_q <= 16'h0000;
            wb_read_data_q  <= 16'h0000;
            wb_memtoreg_q   <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_write_reg_q  <= 3'd0;
            err_q           <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            op_read_q       <= op_read_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_rd_q        <= mem_rd_d;
            mem_wr_q        <= mem_wr_d;
            wb_valid_q      <= wb_valid_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_memtoreg_q   <= wb_memtoreg_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_write_reg_q  <= wb_write_reg_d;
            err_q           <= err_d;
        end
    end

    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_rd        = mem_rd_q;
    assign mem_wr        = mem_wr_q;
    assign wb_valid      = wb_valid_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_read_data  = wb_read_data_q;
    assign wb_MemtoReg   = wb_memtoreg_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_write_reg  = wb_write_reg_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage. Instance A (MAX_WAIT=15) runs
// directed and random instruction streams against a transaction-level model;
// instance B (MAX_WAIT=4) shares the inputs and is checked for timeout.
module tb_mem_stage;
    localparam int MAXW_A = 15;
    localparam int MAXW_B = 4;

    logic        clk, rst;
    logic        in_valid, in_mem_read, in_mem_write, in_reg_write, in_MemtoReg;
    logic [15:0] in_addr, in_wdata;
    logic [2:0]  in_write_reg;
    logic        mem_done;
    logic [15:0] mem_rdata;

    logic [15:0] mem_addr, mem_wdata, wb_alu_result, wb_read_data;
    logic        mem_rd, mem_wr, stall, wb_valid, wb_MemtoReg, wb_reg_write, err;
    logic [2:0]  wb_write_reg;

    logic [15:0] mem_addr_b, mem_wdata_b, wb_alu_result_b, wb_read_data_b;
    logic        mem_rd_b, mem_wr_b, stall_b, wb_valid_b, wb_MemtoReg_b, wb_reg_write_b, err_b;
    logic [2:0]  wb_write_reg_b;

    mem_stage #(.MAX_WAIT(MAXW_A), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_reg_write(in_reg_write), .in_write_reg(in_write_reg), .in_MemtoReg(in_MemtoReg),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .stall(stall), .wb_valid(wb_valid),
        .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
        .wb_MemtoReg(wb_MemtoReg), .wb_reg_write(wb_reg_write),
        .wb_write_reg(wb_write_reg), .err(err)
    );

    mem_stage #(.MAX_WAIT(MAXW_B), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_reg_write(in_reg_write), .in_write_reg(in_write_reg), .in_MemtoReg(in_MemtoReg),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rd(mem_rd_b), .mem_wr(mem_wr_b),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .stall(stall_b), .wb_valid(wb_valid_b),
        .wb_alu_result(wb_alu_result_b), .wb_read_data(wb_read_data_b),
        .wb_MemtoReg(wb_MemtoReg_b), .wb_reg_write(wb_reg_write_b),
        .wb_write_reg(wb_write_reg_b), .err(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the MEM/WB slot and sticky error
    logic        m_valid, m_reg_write, m_err, m_known, m_m2r;
    logic [15:0] m_alu, m_read;
    logic [2:0]  m_wreg;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_reg_write = 0; m_err = 0; m_known = 1;
        m_m2r = 0; m_alu = 0; m_read = 0; m_wreg = 0;
    endtask

    // Present one instruction at posedge+1 and run it to completion.
    // lat = number of WAIT cycles with mem_done low before done is raised.
    task automatic run_instr(input logic v, input logic rd, input logic wr,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] rdata, input logic rw,
                             input logic [2:0] wreg, input logic m2r, input int lat);
        logic is_bad, is_mem, done_seen;
        int   n_stall;
        is_bad = v && ((rd && wr) || ((rd || wr) && addr[0]));
        is_mem = v && (rd != wr) && !is_bad;
        in_valid = v; in_mem_read = rd; in_mem_write = wr; in_addr = addr;
        in_wdata = wdata; in_reg_write = rw; in_write_reg = wreg; in_MemtoReg = m2r;
        mem_done = 1'b0; mem_rdata = 16'h0000;
        n_stall = 0;
        @(negedge clk);
        check_eq("idle_mem_rd", 16'(mem_rd), 16'h0);
        check_eq("idle_mem_wr", 16'(mem_wr), 16'h0);
        check_eq("idle_stall", 16'(stall), 16'(is_mem));
        if (stall) n_stall++;
        @(posedge clk); #1;
        if (!is_mem) begin
            if (!v) begin
                m_valid = 0;
            end else if (is_bad) begin
                m_valid = 1; m_reg_write = 0; m_err = 1; m_known = 0;
            end else begin
                m_valid = 1; m_reg_write = rw; m_known = 1;
                m_alu = addr; m_read = 0; m_wreg = wreg; m_m2r = m2r;
            end
        end else begin
            // ISSUE: a stray mem_done here must be ignored
            mem_done  = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
            @(negedge clk);
            check_eq("issue_mem_rd", 16'(mem_rd), 16'(rd));
            check_eq("issue_mem_wr", 16'(mem_wr), 16'(wr));
            check_eq("issue_mem_addr", mem_addr, addr);
            check_eq("issue_mem_wdata", mem_wdata, wdata);
            check_eq("issue_stall", 16'(stall), 16'h1);
            check_eq("issue_wb_valid", 16'(wb_valid), 16'h0);
            if (stall) n_stall++;
            @(posedge clk); #1;
            done_seen = 0;
            for (int k = 0; k < MAXW_A; k++) begin
                mem_done  = (k == lat);
                mem_rdata = (k == lat) ? rdata : 16'($urandom);
                @(negedge clk);
                check_eq("wait_mem_rd", 16'(mem_rd), 16'h0);
                check_eq("wait_mem_wr", 16'(mem_wr), 16'h0);
                check_eq("wait_mem_addr", mem_addr, addr);
                check_eq("wait_stall", 16'(stall), 16'(k != lat));
                if (stall) n_stall++;
                @(posedge clk); #1;
                if (k == lat) begin
                    done_seen = 1;
                    break;
                end
            end
            mem_done = 1'b0;
            if (done_seen) begin
                m_valid = 1; m_reg_write = rw; m_known = 1;
                m_alu = addr; m_read = rd ? rdata : 16'h0000; m_wreg = wreg; m_m2r = m2r;
            end else begin
                m_valid = 1; m_reg_write = 0; m_err = 1; m_known = 0;
            end
            check_eq("stall_cycles", 16'(n_stall), 16'((lat < MAXW_A) ? 2 + lat : 2 + MAXW_A));
        end
        check_eq("wb_valid", 16'(wb_valid), 16'(m_valid));
        check_eq("wb_reg_write", 16'(wb_reg_write), 16'(m_reg_write));
        check_eq("err", 16'(err), 16'(m_err));
        if (m_known) begin
            check_eq("wb_alu_result", wb_alu_result, m_alu);
            check_eq("wb_read_data", wb_read_data, m_read);
            check_eq("wb_write_reg", 16'(wb_write_reg), 16'(m_wreg));
            check_eq("wb_MemtoReg", 16'(wb_MemtoReg), 16'(m_m2r));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1);
    end

    initial begin
        logic [15:0] a, wd, rdv;
        logic        rd, wr, v;
        int          r, lat;

        rst = 1'b0;
        in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_addr = 0; in_wdata = 0;
        in_reg_write = 0; in_write_reg = 0; in_MemtoReg = 0; mem_done = 0; mem_rdata = 0;
        model_clear();
        #1 rst = 1'b1;
        #1;
        check_eq("rst_mem_addr", mem_addr, 16'h0);
        check_eq("rst_mem_wdata", mem_wdata, 16'h0);
        check_eq("rst_mem_rd", 16'(mem_rd), 16'h0);
        check_eq("rst_mem_wr", 16'(mem_wr), 16'h0);
        check_eq("rst_stall", 16'(stall), 16'h0);
        check_eq("rst_wb_valid", 16'(wb_valid), 16'h0);
        check_eq("rst_wb_alu_result", wb_alu_result, 16'h0);
        check_eq("rst_wb_read_data", wb_read_data, 16'h0);
        check_eq("rst_wb_MemtoReg", 16'(wb_MemtoReg), 16'h0);
        check_eq("rst_wb_reg_write", 16'(wb_reg_write), 16'h0);
        check_eq("rst_wb_write_reg", 16'(wb_write_reg), 16'h0);
        check_eq("rst_err", 16'(err), 16'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases
        run_instr(1, 0, 0, 16'h1234, 16'h0000, 16'h0000, 1, 3'd3, 1, 0);
        run_instr(1, 1, 0, 16'h0040, 16'h0000, 16'hBEEF, 1, 3'd5, 0, 0);
        run_instr(1, 0, 1, 16'h0010, 16'hA5A5, 16'h0000, 0, 3'd0, 0, 4);
        run_instr(1, 1, 0, 16'h0003, 16'h0000, 16'h0000, 1, 3'd2, 0, 0);
        run_instr(0, 0, 0, 16'h5555, 16'h0000, 16'h0000, 1, 3'd7, 1, 0);

        // Random stream
        for (int i = 0; i < 250; i++) begin
            r   = int'($urandom_range(0, 9));
            a   = 16'($urandom);
            wd  = 16'($urandom);
            rdv = 16'($urandom);
            lat = ($urandom_range(0, 15) == 0) ? int'($urandom_range(15, 17))
                                               : int'($urandom_range(0, 5));
            v = 1; rd = 0; wr = 0;
            case (r)
                0:       begin v = 0; rd = 1'($urandom); wr = 1'($urandom); end
                4, 5:    begin rd = 1; a[0] = 1'b0; end
                6, 7:    begin wr = 1; a[0] = 1'b0; end
                8:       begin rd = 1'($urandom); wr = ~rd; a[0] = 1'b1; end
                9:       begin rd = 1; wr = 1; end
                default: ;
            endcase
            run_instr(v, rd, wr, a, wd, rdv, 1'($urandom), 3'($urandom), 1'($urandom), lat);
        end

        // Reset asserted while a load is in WAIT, with err already set
        run_instr(1, 1, 1, 16'h0008, 16'h0000, 16'h0000, 1, 3'd1, 0, 0);
        in_valid = 1; in_mem_read = 1; in_mem_write = 0; in_addr = 16'h0080; mem_done = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("pre_rst_stall", 16'(stall), 16'h1);
        #2;
        rst = 1'b1; in_valid = 0; in_mem_read = 0;
        #1;
        check_eq("wait_rst_mem_rd", 16'(mem_rd), 16'h0);
        check_eq("wait_rst_stall", 16'(stall), 16'h0);
        check_eq("wait_rst_wb_valid", 16'(wb_valid), 16'h0);
        check_eq("wait_rst_err", 16'(err), 16'h0);
        check_eq("wait_rst_mem_addr", mem_addr, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_done = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        check_eq("late_done_stall", 16'(stall), 16'h0);
        @(posedge clk); #1;
        mem_done = 1'b0;
        check_eq("late_done_wb_valid", 16'(wb_valid), 16'h0);
        check_eq("late_done_mem_rd", 16'(mem_rd), 16'h0);
        check_eq("late_done_err", 16'(err), 16'h0);
        check_eq("late_done_read_data", wb_read_data, 16'h0);

        // Timeout on the MAX_WAIT=4 instance, then a normal ALU op
        in_valid = 1; in_mem_read = 1; in_mem_write = 0; in_addr = 16'h0020;
        in_reg_write = 1; in_write_reg = 3'd6; in_MemtoReg = 0;
        @(negedge clk);
        check_eq("to_idle_stall", 16'(stall_b), 16'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("to_issue_mem_rd", 16'(mem_rd_b), 16'h1);
        @(posedge clk); #1;
        for (int k = 0; k < MAXW_B; k++) begin
            @(negedge clk);
            check_eq("to_wait_stall", 16'(stall_b), 16'h1);
            check_eq("to_wait_err", 16'(err_b), 16'h0);
            @(posedge clk); #1;
        end
        check_eq("to_err", 16'(err_b), 16'h1);
        check_eq("to_wb_valid", 16'(wb_valid_b), 16'h1);
        check_eq("to_wb_reg_write", 16'(wb_reg_write_b), 16'h0);
        in_mem_read = 0; in_addr = 16'h1234; in_write_reg = 3'd3; in_MemtoReg = 1;
        @(negedge clk);
        check_eq("to_next_stall", 16'(stall_b), 16'h0);
        @(posedge clk); #1;
        check_eq("to_next_wb_valid", 16'(wb_valid_b), 16'h1);
        check_eq("to_next_alu", wb_alu_result_b, 16'h1234);
        check_eq("to_next_write_reg", 16'(wb_write_reg_b), 16'h3);
        check_eq("to_next_reg_write", 16'(wb_reg_write_b), 16'h1);
        check_eq("to_next_err", 16'(err_b), 16'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
